// File: rtl/program_counter.sv
// Program counter with prioritised redirects (trap > jump > branch > PC+4),
// stall, previous-PC tracking and optional word-alignment enforcement.
module program_counter #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit          ALIGN_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        trap,
  input  logic [31:0] trap_vector,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic [31:0] PC,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_prev,
  output logic        misalign_err
);

  logic [31:0] pc_reg;
  logic [31:0] pc_prev_reg;
  logic        misalign_reg;

  logic        redirect;
  logic [31:0] sel_target;
  logic [31:0] load_target;
  logic        target_misaligned;
  logic [31:0] seq_pc;
  logic [31:0] pc_next;
  logic        misalign_next;

  assign seq_pc = pc_reg + 32'd4;

  always_comb begin
    redirect   = trap | jump | branch;
    sel_target = branch_target;
    if (trap) begin
      sel_target = trap_vector;
    end else if (jump) begin
      sel_target = jump_target;
    end
  end

  // With alignment enforcement the low bits are dropped and the event is flagged.
  generate
    if (ALIGN_CHECK) begin : g_align
      assign load_target       = {sel_target[31:2], 2'b00};
      assign target_misaligned = redirect && (sel_target[1:0] != 2'b00);
    end else begin : g_no_align
      assign load_target       = sel_target;
      assign target_misaligned = 1'b0;
    end
  endgenerate

  always_comb begin
    pc_next       = redirect ? load_target : seq_pc;
    misalign_next = target_misaligned;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg       <= RESET_VECTOR;
      pc_prev_reg  <= RESET_VECTOR;
      misalign_reg <= 1'b0;
    end else if (en) begin
      pc_reg       <= pc_next;
      pc_prev_reg  <= pc_reg;
      misalign_reg <= misalign_next;
    end
  end

  assign PC           = pc_reg;
  assign pc_plus4     = seq_pc;
  assign pc_prev      = pc_prev_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter: table of per-cycle stimulus and
// expected registered outputs, plus a hand sequence for ALIGN_CHECK=0.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        trap;
  logic [31:0] trap_vector;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch;
  logic [31:0] branch_target;

  logic [31:0] pc_a, pc_plus4_a, pc_prev_a;
  logic        mis_a;
  logic [31:0] pc_b, pc_plus4_b, pc_prev_b;
  logic        mis_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  program_counter dut (
    .clk(clk), .reset(reset), .en(en),
    .trap(trap), .trap_vector(trap_vector),
    .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_target(branch_target),
    .PC(pc_a), .pc_plus4(pc_plus4_a), .pc_prev(pc_prev_a), .misalign_err(mis_a)
  );

  program_counter #(.RESET_VECTOR(32'h0000_1000), .ALIGN_CHECK(1'b0)) dut_noalign (
    .clk(clk), .reset(reset), .en(en),
    .trap(trap), .trap_vector(trap_vector),
    .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_target(branch_target),
    .PC(pc_b), .pc_plus4(pc_plus4_b), .pc_prev(pc_prev_b), .misalign_err(mis_b)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        trap;
    logic [31:0] tv;
    logic        jump;
    logic [31:0] jt;
    logic        branch;
    logic [31:0] bt;
    logic [31:0] exp_pc;
    logic [31:0] exp_prev;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic t, input logic [31:0] tv,
                     input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt,
                     input logic [31:0] pc, input logic [31:0] prev, input logic mis);
    vec_t v;
    v.rst_n = r; v.en = e; v.trap = t; v.tv = tv; v.jump = j; v.jt = jt;
    v.branch = b; v.bt = bt; v.exp_pc = pc; v.exp_prev = prev; v.exp_mis = mis;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic t, input logic [31:0] tv,
                       input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
    @(negedge clk);
    reset = r; en = e; trap = t; trap_vector = tv;
    jump = j; jump_target = jt; branch = b; branch_target = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; trap = 1'b0; jump = 1'b0; branch = 1'b0;
    trap_vector = '0; jump_target = '0; branch_target = '0;

    //   rst en trap tv          jump jt            br bt            pc            prev          mis
    add(0, 1, 0, 32'h0,        1, 32'h40,        0, 32'h0,        32'h0,        32'h0,        0); // reset wins over jump
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h4,        32'h0,        0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h8,        32'h4,        0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'hC,        32'h8,        0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h10,       32'h10,       32'hC,        0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h14,       32'h10,       0);
    add(1, 1, 0, 32'h0,        1, 32'h20,        1, 32'h10,       32'h20,       32'h14,       0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h24,       32'h20,       0);
    add(1, 1, 1, 32'h100,      1, 32'h20,        1, 32'h10,       32'h100,      32'h24,       0);
    add(1, 0, 0, 32'h0,        1, 32'h200,       0, 32'h0,        32'h100,      32'h24,       0);
    add(1, 0, 1, 32'h300,      1, 32'h200,       0, 32'h0,        32'h100,      32'h24,       0);
    add(1, 0, 0, 32'h0,        1, 32'h200,       1, 32'h400,      32'h100,      32'h24,       0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h104,      32'h100,      0);
    add(1, 1, 0, 32'h0,        1, 32'h23,        0, 32'h0,        32'h20,       32'h104,      1);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h24,       32'h20,       0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h13,       32'h10,       32'h24,       1);
    add(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h10,       32'h24,       1);
    add(1, 1, 0, 32'h0,        1, 32'h40,        0, 32'h0,        32'h40,       32'h10,       0);
    add(0, 1, 0, 32'h0,        1, 32'h80,        0, 32'h0,        32'h0,        32'h0,        0);
    add(1, 1, 1, 32'h101,      0, 32'h0,         0, 32'h0,        32'h100,      32'h0,        1);
    add(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    add(1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        32'hFFFF_FFFC, 0);
    add(1, 1, 0, 32'h0,        0, 32'h0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,      1);
    add(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        32'hFFFF_FFFC, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].trap, vecs[i].tv,
            vecs[i].jump, vecs[i].jt, vecs[i].branch, vecs[i].bt);
      chk($sformatf("v%0d pc", i), pc_a, vecs[i].exp_pc);
      chk($sformatf("v%0d pc_plus4", i), pc_plus4_a, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d pc_prev", i), pc_prev_a, vecs[i].exp_prev);
      chk($sformatf("v%0d misalign", i), {31'd0, mis_a}, {31'd0, vecs[i].exp_mis});
      $display("vec %0d: pc=%h prev=%h mis=%0d", i, pc_a, pc_prev_a, mis_a);
    end

    // Unchecked-alignment instance: targets load verbatim, flag never rises.
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    chk("na reset pc", pc_b, 32'h1000);
    chk("na reset prev", pc_prev_b, 32'h1000);
    drive(1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    chk("na first pc", pc_b, 32'h1004);
    drive(1, 1, 0, 32'h0, 1, 32'h23, 0, 32'h0);
    chk("na jump pc", pc_b, 32'h23);
    chk("na jump mis", {31'd0, mis_b}, 32'd0);
    chk("na jump prev", pc_prev_b, 32'h1004);
    drive(1, 1, 1, 32'h102, 0, 32'h0, 0, 32'h0);
    chk("na trap pc", pc_b, 32'h102);
    chk("na trap mis", {31'd0, mis_b}, 32'd0);
    drive(1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    chk("na seq pc", pc_b, 32'h106);
    chk("na seq plus4", pc_plus4_b, 32'h10A);
    $display("noalign seq: pc=%h prev=%h mis=%0d", pc_b, pc_prev_b, mis_b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
